// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle for chunked_adder.
// master drives operands and accepts results; slave is the adder itself.
interface chunked_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock,
// carry held in a flop between slices. Operands are captured on acceptance
// and shifted right one chunk per busy cycle; the result is shifted in from
// the top so that after N slices it sits in place.
// Optional feature macro: CHUNKED_ADDER_FLAGS_EN (ovf/zero flags; tied 0 if undefined).
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    chunked_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] sum_shift;
    logic             accept;
    logic             busy;
    logic             last;

    // One CHUNK-bit ripple: {carry out, slice sum}
    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;
    assign busy   = (state == BUSY);
    assign last   = (cnt == LAST);
    assign part   = add_chunk(op_a[CHUNK-1:0], op_b[CHUNK-1:0], carry);

    generate
        if (N == 1) begin : g_single
            assign sum_shift = part[CHUNK-1:0];
        end else begin : g_multi
            assign sum_shift = {part[CHUNK-1:0], sum_r[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = BUSY;
            BUSY:    if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Operand shifters: subtrahend is inverted at capture, lowest chunk feeds the adder
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= bus.a;
            op_b <= bus.sub ? ~bus.b : bus.b;
        end else if (busy) begin
            op_a <= op_a >> CHUNK;
            op_b <= op_b >> CHUNK;
        end
    end

    // Carry flop, chunk counter, sum and carry-out; cleared by reset, so an aborted op leaves nothing behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            carry <= bus.sub | bus.cin;
            cnt   <= '0;
        end else if (busy) begin
            carry <= part[CHUNK];
            sum_r <= sum_shift;
            if (last) cout_r <= part[CHUNK];
            else      cnt    <= cnt + CW'(1);
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

`ifdef CHUNKED_ADDER_FLAGS_EN
    logic ovf_r;
    logic zero_r;
    logic zacc;

    // Flags: ovf = carry into MSB xor carry out; zero accumulated slice by slice to keep the path short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            zacc   <= 1'b0;
        end else if (accept) begin
            zacc <= 1'b1;
        end else if (busy) begin
            zacc <= zacc & (part[CHUNK-1:0] == '0);
            if (last) begin
                ovf_r  <= part[CHUNK] ^ part[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
                zero_r <= zacc & (part[CHUNK-1:0] == '0);
            end
        end
    end

    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif
endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, carry rippling through a registered carry flop. It generalises the 4-bit ripple adder to arbitrary width, adds subtract mode, and wraps the datapath in valid/ready handshakes. It lets wide additions close timing where a full-width ripple chain would not. It sits between the ALU operand muxes and the writeback path of multi-cycle execution units.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of CHUNK
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation; CHUNK = WIDTH gives N = 1
- clk  in  1  clock, rising edge active
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in; add mode only
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)
- zero  out  1  sum == 0

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: in_ready = 1. On in_valid && in_ready: capture a, b (inverted if sub), carry seed (cin, or 1 if sub), clear chunk counter → BUSY.
- BUSY: each cycle adds chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of captured operands plus carry flop; writes slice into sum register, updates carry flop, k++. After chunk N-1: latch cout, ovf, zero → DONE.
- DONE: out_valid = 1; sum/cout/ovf/zero held stable. On out_ready → IDLE.
- Captured operands are the only ones used; a/b/cin/sub changes after acceptance ignored.
- in_ready is 0 in BUSY and DONE; no new operation accepted in the cycle the result is consumed.
- Counter width ceil(log2(N)), minimum 1; no wrap past N-1.
- Reset (any state, incl. mid-BUSY): abort, state IDLE, carry/counter cleared, result discarded.
- Reset values: in_ready 1, out_valid 0, sum 0, cout 0, ovf 0, zero 0.

## Timing
- Acceptance at edge E0; chunks computed at E1..EN; out_valid high in cycle following EN, i.e. N cycles after acceptance edge.
- WIDTH=32, CHUNK=4: 8-cycle latency; minimum initiation interval N+2 cycles (accept, N busy, one IDLE cycle after output handshake).
- All outputs registered except in_ready (decoded from state register); no input-to-output combinational path.
- Critical path: one CHUNK-bit ripple plus carry flop.

## Configuration
- Macro CHUNKED_ADDER_FLAGS_EN.
- Defined: ovf and zero computed and latched as above.
- Undefined: ovf and zero tied to 0, flag logic not synthesised; sum, cout, handshakes and latency unchanged.

## Test plan
- WIDTH=32, CHUNK=4, add a=0xFFFF_FFFF, b=1, cin=0 → sum 0x0000_0000, cout 1, zero 1, ovf 0; out_valid rises 8 cycles after acceptance.
- Sub a=5, b=7 → sum 0xFFFF_FFFE, cout 0, ovf 0, zero 0; sub a=7, b=5 → sum 2, cout 1.
- Add a=0x7FFF_FFFF, b=1, cin=0 → sum 0x8000_0000, ovf 1, cout 0; without macro ovf 0 and sum identical.
- Backpressure: out_ready low 5 cycles in DONE, a/b toggled during BUSY/DONE → sum/flags stable, in_ready 0, result matches captured operands.
- Reset asserted mid-BUSY at chunk 3 → out_valid 0, in_ready 1 immediately; next op a=0x1234_5678, b=0x1111_1111, cin=1 → sum 0x2345_678A.
- WIDTH=8, CHUNK=8: add a=0x80, b=0x80 → sum 0x00, cout 1, ovf 1, zero 1, out_valid 1 cycle after acceptance.
